// File: rtl/alarm_clock_counter.sv
// Alarm clock: a prescaled seconds/minutes/hours counter with a three-state
// alarm controller (IDLE, RINGING, SNOOZE). The time registers, sec_pulse and
// state are all registered. ring is decoded from state.
//
// Control inputs (en, load, ack, snooze, alarm_en) are levels. Each one is
// sampled on every rising clk edge; there is no valid/ready handshake. The
// state output exposes the alarm FSM so that checkers can bind to it directly.
module alarm_clock_counter #(
  parameter int DIV        = 1,
  parameter int SEC_MOD    = 60,
  parameter int MIN_MOD    = 60,
  parameter int HR_MOD     = 24,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 30,
  localparam int SW = $clog2(SEC_MOD),
  localparam int MW = $clog2(MIN_MOD),
  localparam int HW = $clog2(HR_MOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [SW-1:0] load_sec,
  input  logic [MW-1:0] load_min,
  input  logic [HW-1:0] load_hr,
  input  logic [MW-1:0] alarm_min,
  input  logic [HW-1:0] alarm_hr,
  input  logic          alarm_en,
  input  logic          ack,
  input  logic          snooze,
  output logic [SW-1:0] seconds,
  output logic [MW-1:0] minutes,
  output logic [HW-1:0] hours,
  output logic          sec_pulse,
  output logic          ring,
  output logic [1:0]    state
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RINGING = 2'b01;
  localparam logic [1:0] ST_SNOOZE  = 2'b10;

  localparam int PW           = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SNOOZE_TICKS = SNOOZE_MIN * SEC_MOD;
  localparam int TMAX         = (SNOOZE_TICKS > RING_SEC) ? SNOOZE_TICKS : RING_SEC;
  localparam int TW           = $clog2(TMAX + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [SW-1:0] SEC_LAST  = SW'(SEC_MOD - 1);
  localparam logic [MW-1:0] MIN_LAST  = MW'(MIN_MOD - 1);
  localparam logic [HW-1:0] HR_LAST   = HW'(HR_MOD - 1);
  localparam logic [TW-1:0] RING_LAST = TW'(RING_SEC - 1);
  localparam logic [TW-1:0] SNZ_LAST  = TW'(SNOOZE_TICKS - 1);

  logic [PW-1:0] presc;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [1:0]    state_nxt;
  logic          tick, adv, match;
  logic [SW-1:0] nxt_sec, ld_sec;
  logic [MW-1:0] nxt_min, ld_min;
  logic [HW-1:0] nxt_hr, ld_hr;

  // A tick only advances time when no load competes with it in that cycle.
  assign tick = en && (presc == PRE_LAST);
  assign adv  = tick && !load;
  assign ring = (state == ST_RINGING);

  // Compute the incremented time, and clamp load values that are out of range to zero.
  always_comb begin
    nxt_sec = (seconds == SEC_LAST) ? '0 : seconds + 1'b1;
    nxt_min = minutes;
    nxt_hr  = hours;
    if (seconds == SEC_LAST) begin
      nxt_min = (minutes == MIN_LAST) ? '0 : minutes + 1'b1;
      if (minutes == MIN_LAST)
        nxt_hr = (hours == HR_LAST) ? '0 : hours + 1'b1;
    end
    ld_sec = (int'(load_sec) < SEC_MOD) ? load_sec : '0;
    ld_min = (int'(load_min) < MIN_MOD) ? load_min : '0;
    ld_hr  = (int'(load_hr)  < HR_MOD)  ? load_hr  : '0;
    // The alarm only matches on the tick that lands on hh:mm:00. This stops
    // it from firing a second time later in the same minute.
    match = (nxt_sec == '0) && (nxt_min == alarm_min) && (nxt_hr == alarm_hr);
  end

  // Prescaler, time registers and sec_pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= '0;
      seconds   <= '0;
      minutes   <= '0;
      hours     <= '0;
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= adv;
      if (load) begin
        presc   <= '0;
        seconds <= ld_sec;
        minutes <= ld_min;
        hours   <= ld_hr;
      end else if (en) begin
        presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
        if (tick) begin
          seconds <= nxt_sec;
          minutes <= nxt_min;
          hours   <= nxt_hr;
        end
      end
    end
  end

  // Alarm FSM. RINGING and SNOOZE share one tick timer, because only one of
  // them can be active at a time. Priority order is alarm_en, then ack, then
  // snooze, then timer expiry.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      ST_IDLE: begin
        tmr_nxt = '0;
        if (alarm_en && adv && match) state_nxt = ST_RINGING;
      end
      ST_RINGING: begin
        if (!alarm_en || ack) begin
          state_nxt = ST_IDLE;
          tmr_nxt   = '0;
        end else if (snooze) begin
          state_nxt = ST_SNOOZE;
          tmr_nxt   = '0;
        end else if (adv) begin
          if (tmr == RING_LAST) begin
            state_nxt = ST_IDLE;
            tmr_nxt   = '0;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (!alarm_en || ack) begin
          state_nxt = ST_IDLE;
          tmr_nxt   = '0;
        end else if (adv) begin
          if (tmr == SNZ_LAST) begin
            state_nxt = ST_RINGING;
            tmr_nxt   = '0;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  // FSM state and timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

endmodule

// File: tb/tb_alarm_clock_counter.sv
// Directed bench for alarm_clock_counter, run with small moduli so that wraps and
// alarms are reached in a few cycles. Each step queues the expected
// {hours, minutes, seconds, state, sec_pulse, ring}. It then lets one clock edge
// pass and compares the DUT against the head of the queue.
module tb_alarm_clock_counter;

  localparam int SW = 4;
  localparam int MW = 3;
  localparam int HW = 2;
  localparam int EW = HW + MW + SW + 2 + 1 + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, load, alarm_en, ack, snooze;
  logic [SW-1:0] load_sec;
  logic [MW-1:0] load_min, alarm_min;
  logic [HW-1:0] load_hr, alarm_hr;
  logic [SW-1:0] seconds;
  logic [MW-1:0] minutes;
  logic [HW-1:0] hours;
  logic          sec_pulse, ring;
  logic [1:0]    state;

  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  alarm_clock_counter #(
    .DIV(1), .SEC_MOD(10), .MIN_MOD(6), .HR_MOD(4), .SNOOZE_MIN(1), .RING_SEC(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
    .alarm_min(alarm_min), .alarm_hr(alarm_hr),
    .alarm_en(alarm_en), .ack(ack), .snooze(snooze),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .sec_pulse(sec_pulse), .ring(ring), .state(state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Queue one expected result. ring is expected high only in RINGING.
  task automatic push_exp(input int h, input int m, input int s, input logic [1:0] st, input logic p);
    exp_q.push_back({HW'(h), MW'(m), SW'(s), st, p, (st == 2'b01)});
  endtask

  // Scoreboard compare: pop the oldest expectation and check it against the DUT.
  task automatic check(input string tag);
    logic [EW-1:0] exp_v, obs_v;
    obs_v = {hours, minutes, seconds, state, sec_pulse, ring};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed=%h expected=<empty queue>", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs_v === exp_v) else begin
        fails++;
        $error("FAIL %s: observed h:m:s=%0d:%0d:%0d st=%b pulse=%b ring=%b (%h) expected %h",
               tag, hours, minutes, seconds, state, sec_pulse, ring, obs_v, exp_v);
      end
    end
  endtask

  // Check the DUT without waiting for a clock edge.
  task automatic expect_now(input string tag, input int h, input int m, input int s, input logic [1:0] st, input logic p);
    push_exp(h, m, s, st, p);
    check(tag);
  endtask

  // Let one rising edge pass, then check the DUT 1 time unit later.
  task automatic step(input string tag, input int h, input int m, input int s, input logic [1:0] st, input logic p);
    push_exp(h, m, s, st, p);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic set_load(input int h, input int m, input int s);
    load     = 1'b1;
    load_hr  = HW'(h);
    load_min = MW'(m);
    load_sec = SW'(s);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; alarm_en = 1'b0; ack = 1'b0; snooze = 1'b0;
    load_sec = '0; load_min = '0; load_hr = '0; alarm_min = '0; alarm_hr = '0;
    #3;
    expect_now("reset_state", 0, 0, 0, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Full wrap from 3:5:9 to 0:0:0, with a one-cycle sec_pulse.
    set_load(3, 5, 9);
    step("load_3_5_9", 3, 5, 9, 2'b00, 1'b0);
    load = 1'b0; en = 1'b1;
    step("wrap_to_zero", 0, 0, 0, 2'b00, 1'b1);
    en = 1'b0;
    step("pulse_one_cycle", 0, 0, 0, 2'b00, 1'b0);

    // Minute carry into hours, without wrapping.
    set_load(0, 5, 9); en = 1'b1;
    step("load_0_5_9", 0, 5, 9, 2'b00, 1'b0);
    load = 1'b0;
    step("carry_to_hour", 1, 0, 0, 2'b00, 1'b1);

    // Alarm fires at 1:2:0. Then it times out after 3 ticks and does not retrigger.
    alarm_hr = 2'd1; alarm_min = 3'd2; alarm_en = 1'b1;
    set_load(1, 1, 8); en = 1'b0;
    step("load_1_1_8", 1, 1, 8, 2'b00, 1'b0);
    load = 1'b0; en = 1'b1;
    step("pre_alarm", 1, 1, 9, 2'b00, 1'b1);
    step("alarm_ring", 1, 2, 0, 2'b01, 1'b1);
    step("ring_t1", 1, 2, 1, 2'b01, 1'b1);
    step("ring_t2", 1, 2, 2, 2'b01, 1'b1);
    step("ring_timeout", 1, 2, 3, 2'b00, 1'b1);
    for (int i = 4; i < 10; i++) step("no_retrigger", 1, 2, i, 2'b00, 1'b1);
    step("next_minute", 1, 3, 0, 2'b00, 1'b1);

    // Snooze: 10 ticks in SNOOZE (snooze held for one of them), then ring again, then ack.
    set_load(1, 1, 9);
    step("load_prio_no_pulse", 1, 1, 9, 2'b00, 1'b0);
    load = 1'b0;
    step("ring_again", 1, 2, 0, 2'b01, 1'b1);
    snooze = 1'b1;
    step("enter_snooze", 1, 2, 1, 2'b10, 1'b1);
    step("snooze_ignored", 1, 2, 2, 2'b10, 1'b1);
    snooze = 1'b0;
    for (int i = 3; i < 10; i++) step("snoozing", 1, 2, i, 2'b10, 1'b1);
    step("snoozing_end", 1, 3, 0, 2'b10, 1'b1);
    step("snooze_expire", 1, 3, 1, 2'b01, 1'b1);
    ack = 1'b1;
    step("ack_ringing", 1, 3, 2, 2'b00, 1'b1);
    ack = 1'b0;

    // ack wins over snooze. ack with en=0 also clears, and time stays frozen.
    set_load(1, 1, 9);
    step("reload", 1, 1, 9, 2'b00, 1'b0);
    load = 1'b0;
    step("ring_p1", 1, 2, 0, 2'b01, 1'b1);
    ack = 1'b1; snooze = 1'b1;
    step("ack_over_snooze", 1, 2, 1, 2'b00, 1'b1);
    ack = 1'b0; snooze = 1'b0;
    set_load(1, 1, 9);
    step("reload2", 1, 1, 9, 2'b00, 1'b0);
    load = 1'b0;
    step("ring_p2", 1, 2, 0, 2'b01, 1'b1);
    en = 1'b0; ack = 1'b1;
    step("ack_en0", 1, 2, 0, 2'b00, 1'b0);
    ack = 1'b0;
    step("frozen", 1, 2, 0, 2'b00, 1'b0);

    // The ring timer holds while en=0. alarm_en=0 forces IDLE.
    en = 1'b1; set_load(1, 1, 9);
    step("reload3", 1, 1, 9, 2'b00, 1'b0);
    load = 1'b0;
    step("ring_p3", 1, 2, 0, 2'b01, 1'b1);
    en = 1'b0;
    step("hold_ring_a", 1, 2, 0, 2'b01, 1'b0);
    step("hold_ring_b", 1, 2, 0, 2'b01, 1'b0);
    en = 1'b1;
    step("held_t1", 1, 2, 1, 2'b01, 1'b1);
    step("held_t2", 1, 2, 2, 2'b01, 1'b1);
    step("held_timeout", 1, 2, 3, 2'b00, 1'b1);
    set_load(1, 1, 9);
    step("reload4", 1, 1, 9, 2'b00, 1'b0);
    load = 1'b0;
    step("ring_p4", 1, 2, 0, 2'b01, 1'b1);
    alarm_en = 1'b0;
    step("alarm_en_off", 1, 2, 1, 2'b00, 1'b1);
    alarm_en = 1'b1;

    // Asynchronous reset in the middle of a ring. Then load out-of-range values and resume.
    set_load(1, 1, 9);
    step("reload5", 1, 1, 9, 2'b00, 1'b0);
    load = 1'b0;
    step("ring_p5", 1, 2, 0, 2'b01, 1'b1);
    rst = 1'b0;
    #2;
    expect_now("async_reset", 0, 0, 0, 2'b00, 1'b0);
    step("reset_held", 0, 0, 0, 2'b00, 1'b0);
    rst = 1'b1; en = 1'b0;
    set_load(2, 7, 12);
    step("load_out_of_range", 2, 0, 0, 2'b00, 1'b0);
    load = 1'b0; en = 1'b1;
    step("resume_count", 2, 0, 1, 2'b00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_clock_counter.md
ALARM_CLOCK_COUNTER -- requirements
Module: alarm_clock_counter

Interface
REQ-001 SHALL provide parameter DIV, default 1: clk cycles per second tick.
REQ-002 SHALL provide parameter SEC_MOD, default 60: seconds modulus.
REQ-003 SHALL provide parameter MIN_MOD, default 60: minutes modulus.
REQ-004 SHALL provide parameter HR_MOD, default 24: hours modulus.
REQ-005 SHALL provide parameter SNOOZE_MIN, default 5: snooze length in minutes.
REQ-006 SHALL provide parameter RING_SEC, default 30: auto-stop ring length in seconds.
REQ-007 SHALL size widths as SW=$clog2(SEC_MOD), MW=$clog2(MIN_MOD), HW=$clog2(HR_MOD).
REQ-008 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-009 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-010 SHALL have port en, input, 1, count enable.
REQ-011 SHALL have port load, input, 1, time load strobe.
REQ-012 SHALL have ports load_sec/load_min/load_hr, input, SW/MW/HW, load values.
REQ-013 SHALL have ports alarm_min/alarm_hr, input, MW/HW, alarm time, sampled every cycle.
REQ-014 SHALL have ports alarm_en, ack, snooze, inputs, 1 each, level-sampled.
REQ-015 SHALL have ports seconds/minutes/hours, output, SW/MW/HW, registered time.
REQ-016 SHALL have port sec_pulse, output, 1, one-cycle pulse per tick-driven advance.
REQ-017 SHALL have ports ring, output, 1, and state, output, 2 (00 IDLE, 01 RINGING, 10 SNOOZE).

Function
REQ-018 SHALL run prescaler 0..DIV-1 only while en=1; tick = en and prescaler==DIV-1.
REQ-019 SHALL on tick advance seconds; at SEC_MOD-1 wrap to 0 and carry to minutes.
REQ-020 SHALL wrap minutes at MIN_MOD-1 with carry to hours; hours wrap at HR_MOD-1 to 0 (23:59:59 -> 00:00:00).
REQ-021 SHALL give load priority over tick: fields take load values next edge, prescaler clears, no sec_pulse.
REQ-022 SHALL load any out-of-range field (>= its modulus) as 0.
REQ-023 SHALL hold time, prescaler, ring and snooze timers while en=0; FSM still honours ack, snooze, alarm_en.
REQ-024 SHALL enter RINGING from IDLE on the edge a tick makes time alarm_hr:alarm_min:00 while alarm_en=1; load never triggers.
REQ-025 SHALL assert ring combinationally from state==RINGING only.
REQ-026 SHALL in RINGING: ack -> IDLE; snooze -> SNOOZE; RING_SEC ticks without action -> IDLE.
REQ-027 SHALL in SNOOZE count SNOOZE_MIN*SEC_MOD ticks, then -> RINGING with ring timer restarted.
REQ-028 SHALL in SNOOZE: ack -> IDLE; snooze ignored.
REQ-029 SHALL force IDLE from any state next edge when alarm_en=0.
REQ-030 SHALL resolve same-cycle priority: alarm_en=0 > ack > snooze > timer expiry.
REQ-031 SHALL not retrigger a ring for the same minute after ack/timeout (match needs seconds==00 via tick).

Reset
REQ-032 SHALL on rst=0 immediately clear seconds, minutes, hours, prescaler, timers, sec_pulse to 0 and state to IDLE (ring=0).
REQ-033 SHALL abandon RINGING/SNOOZE when reset asserts mid-operation; no ring after release until next match.
REQ-034 SHALL resume counting on the first edge after rst deasserts when en=1.

Verification (DIV=1, SEC_MOD=10, MIN_MOD=6, HR_MOD=4, SNOOZE_MIN=1, RING_SEC=3)
REQ-035 SHALL cover wrap: load 3:5:9, en=1, one tick -> 0:0:0, sec_pulse=1 one cycle.
REQ-036 SHALL cover alarm: alarm 1:2, load 1:1:8, 2 ticks -> time 1:2:0, state=01, ring=1 same edge.
REQ-037 SHALL cover timeout: ring, 3 ticks, no ack -> state=00; further ticks in 1:2 do not retrigger.
REQ-038 SHALL cover snooze: ring, snooze=1 -> state=10; 10 ticks later -> state=01; ack -> 00.
REQ-039 SHALL cover priority: in RINGING, ack=snooze=1 same cycle -> 00; en=0 with ack -> 00, time frozen.
REQ-040 SHALL cover reset: rst=0 mid-ring/mid-count -> ring=0, time 0:0:0 without clk edge; load 2:7:12 -> 2:0:0.
